// File: rtl/interleave_pkg.sv
// Shared pointer type and stepping helpers for the block interleaver and deinterleaver.
package interleave_pkg;

    localparam int PTR_W = 16;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    typedef struct packed {
        logic             bank;
        logic [PTR_W-1:0] lane;
        logic [PTR_W-1:0] idx;
    } ptr_t;

    // True when the pointer sits on the final sample of a group.
    function automatic logic ptr_last(ptr_t p, int unsigned lane_max, int unsigned idx_max);
        return (p.lane == lane_max[PTR_W-1:0]) && (p.idx == idx_max[PTR_W-1:0]);
    endfunction

    // Advance a pointer; lane_inner selects which field is the fast counter.
    // The last sample of a group toggles the bank and zeroes both fields.
    function automatic ptr_t ptr_next(ptr_t p, int unsigned lane_max, int unsigned idx_max,
                                      logic lane_inner);
        ptr_t n;
        n = p;
        if (ptr_last(p, lane_max, idx_max)) begin
            n.bank = ~p.bank;
            n.lane = '0;
            n.idx  = '0;
        end else if (lane_inner) begin
            if (p.lane == lane_max[PTR_W-1:0]) begin
                n.lane = '0;
                n.idx  = p.idx + PTR_ONE;
            end else begin
                n.lane = p.lane + PTR_ONE;
            end
        end else begin
            if (p.idx == idx_max[PTR_W-1:0]) begin
                n.idx  = '0;
                n.lane = p.lane + PTR_ONE;
            end else begin
                n.idx  = p.idx + PTR_ONE;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/pingpong_block_ram.sv
// Two-bank sample store: one write port, one registered read port.
// The read register returns 0 on idle cycles so it can drive data_out directly.
module pingpong_block_ram #(
    parameter int BITS  = 8,
    parameter int DEPTH = 60,
    parameter int AW    = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [BITS-1:0] i_wdata,
    input  logic            i_re,
    input  logic [AW-1:0]   i_raddr,
    output logic [BITS-1:0] o_rdata
);

    logic [BITS-1:0] r_mem [DEPTH];
    logic [BITS-1:0] r_rdata;

    // Sample storage; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered read, forced to zero when no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
        else           r_rdata <= '0;
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/interleave_block_input.sv
// Block interleaver: writes IIR blocks of N samples lane-major into one bank,
// reads them index-major from the other bank, ping-ponging without stalls.
module interleave_block_input
    import interleave_pkg::*;
#(
    parameter int BITS = 8,
    parameter int IIR  = 3,
    parameter int N    = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sync,
    input  logic [BITS-1:0] data_in,
    output logic            out_valid,
    output logic [BITS-1:0] data_out,
    output logic            out_group_end,
    output logic            sync_err
);

    localparam int LW    = $clog2(IIR);
    localparam int IW    = $clog2(N);
    localparam int DEPTH = 2 * IIR * N;
    localparam int AW    = $clog2(DEPTH);

    logic          r_wr_bank, r_rd_bank;
    logic [LW-1:0] r_wr_lane, r_rd_lane;
    logic [IW-1:0] r_wr_idx,  r_rd_idx;
    logic [1:0]    r_full;
    logic          r_out_valid, r_out_end, r_sync_err;

    ptr_t          w_wr_cur, w_wr_nxt, w_rd_cur, w_rd_nxt;
    logic          w_in_ready, w_accept, w_resync, w_wr_last;
    logic          w_rd_active, w_rd_last;
    logic [LW-1:0] w_wr_lane_eff;
    logic [IW-1:0] w_wr_idx_eff;
    logic [AW-1:0] w_waddr, w_raddr;

    assign w_wr_cur = {r_wr_bank, PTR_W'(r_wr_lane), PTR_W'(r_wr_idx)};
    assign w_rd_cur = {r_rd_bank, PTR_W'(r_rd_lane), PTR_W'(r_rd_idx)};
    assign w_wr_nxt = ptr_next(w_wr_cur, IIR - 1, N - 1, 1'b0);
    assign w_rd_nxt = ptr_next(w_rd_cur, IIR - 1, N - 1, 1'b1);

    // Ready depends only on flag/pointer registers.
    assign w_in_ready = !r_full[r_wr_bank];
    assign w_accept   = in_valid && w_in_ready;

    // A sync marker anywhere but (0,0) restarts the group at (0,0) of the same bank.
    assign w_resync      = w_accept && in_sync && ((r_wr_lane != '0) || (r_wr_idx != '0));
    assign w_wr_lane_eff = w_resync ? '0 : r_wr_lane;
    assign w_wr_idx_eff  = w_resync ? '0 : r_wr_idx;
    assign w_wr_last     = w_accept && !w_resync && ptr_last(w_wr_cur, IIR - 1, N - 1);

    assign w_rd_active = r_full[r_rd_bank];
    assign w_rd_last   = w_rd_active && ptr_last(w_rd_cur, IIR - 1, N - 1);

    assign w_waddr = AW'((32'(r_wr_bank) * IIR + 32'(w_wr_lane_eff)) * N + 32'(w_wr_idx_eff));
    assign w_raddr = AW'((32'(r_rd_bank) * IIR + 32'(r_rd_lane)) * N + 32'(r_rd_idx));

    // Write pointer: lane-major stepping, resync jumps to (0,1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_wr_lane <= '0;
            r_wr_idx  <= '0;
        end else if (w_resync) begin
            r_wr_lane <= '0;
            r_wr_idx  <= IW'(1);
        end else if (w_accept) begin
            r_wr_bank <= w_wr_nxt.bank;
            r_wr_lane <= w_wr_nxt.lane[LW-1:0];
            r_wr_idx  <= w_wr_nxt.idx[IW-1:0];
        end
    end

    // Read pointer: index-major stepping whenever the read bank is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_bank <= 1'b0;
            r_rd_lane <= '0;
            r_rd_idx  <= '0;
        end else if (w_rd_active) begin
            r_rd_bank <= w_rd_nxt.bank;
            r_rd_lane <= w_rd_nxt.lane[LW-1:0];
            r_rd_idx  <= w_rd_nxt.idx[IW-1:0];
        end
    end

    // Bank-full flags; a same-edge set and clear always hit different banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            if (w_wr_last) r_full[r_wr_bank] <= 1'b1;
            if (w_rd_last) r_full[r_rd_bank] <= 1'b0;
        end
    end

    // Output qualifiers aligned with the registered RAM read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_end   <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_out_valid <= w_rd_active;
            r_out_end   <= w_rd_last;
            r_sync_err  <= w_resync;
        end
    end

    pingpong_block_ram #(
        .BITS  (BITS),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_accept),
        .i_waddr (w_waddr),
        .i_wdata (data_in),
        .i_re    (w_rd_active),
        .i_raddr (w_raddr),
        .o_rdata (data_out)
    );

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign out_group_end = r_out_end;
    assign sync_err      = r_sync_err;

endmodule

// File: tb/tb_interleave_block_input.sv
// Randomized bench for interleave_block_input against a group-level reference model.
module tb_interleave_block_input;

    localparam int BITS = 8;
    localparam int IIR  = 3;
    localparam int N    = 4;
    localparam int L    = IIR * N;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_sync  = 1'b0;
    logic [BITS-1:0] data_in  = '0;
    logic            in_ready, out_valid, out_group_end, sync_err;
    logic [BITS-1:0] data_out;

    always #5 clk = ~clk;

    interleave_block_input #(.BITS(BITS), .IIR(IIR), .N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sync       (in_sync),
        .data_in       (data_in),
        .out_valid     (out_valid),
        .data_out      (data_out),
        .out_group_end (out_group_end),
        .sync_err      (sync_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected output stream stamped with the clock edge it appears on.
    typedef struct {
        int              ecyc;
        logic [BITS-1:0] d;
        logic            last;
    } exp_t;

    exp_t            expq[$];
    logic [BITS-1:0] grp[$];
    int              grp_start[$];
    int              cyc       = 0;
    int              next_free = 0;
    int              serr_cyc  = -1;
    int              accepts   = 0;

    // A full group is emitted sample-interleaved, starting the edge after completion
    // or straight after the previous group, whichever is later.
    function automatic void complete_group();
        int start, k;
        start = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        k = 0;
        for (int idx = 0; idx < N; idx++)
            for (int lane = 0; lane < IIR; lane++) begin
                expq.push_back('{start + k, grp[lane * N + idx], (k == L - 1)});
                k++;
            end
        next_free = start + L;
        grp_start.push_back(start);
        grp.delete();
    endfunction

    function automatic void model_accept(input logic s, input logic [BITS-1:0] d);
        accepts++;
        if (s && grp.size() != 0) begin
            grp.delete();
            serr_cyc = cyc;
        end
        grp.push_back(d);
        if (grp.size() == L) complete_group();
    endfunction

    // A group's bank stays occupied until the edge carrying its last output sample.
    function automatic int model_full();
        int n;
        while (grp_start.size() > 0 && grp_start[0] + L - 1 <= cyc) void'(grp_start.pop_front());
        n = grp_start.size();
        return n;
    endfunction

    function automatic void model_clear();
        expq.delete();
        grp.delete();
        grp_start.delete();
        next_free = 0;
        serr_cyc  = -1;
    endfunction

    task automatic check_outputs();
        if (expq.size() > 0 && expq[0].ecyc == cyc) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("data_out", 32'(data_out), 32'(expq[0].d));
            check("group_end", 32'(out_group_end), 32'(expq[0].last));
            void'(expq.pop_front());
        end else begin
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_data", 32'(data_out), 32'd0);
            check("idle_end", 32'(out_group_end), 32'd0);
        end
        check("sync_err", 32'(sync_err), 32'(serr_cyc == cyc));
        check("in_ready", 32'(in_ready), 32'(model_full() < 2));
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge,
    // compare at the next falling edge.
    task automatic step(input logic v, input logic s, input logic [BITS-1:0] d);
        logic rdy;
        in_valid = v;
        in_sync  = s;
        data_in  = d;
        rdy      = in_ready;
        @(posedge clk);
        cyc++;
        if (v && rdy) model_accept(s, d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, BITS'($urandom));
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_sync  = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_end", 32'(out_group_end), 32'd0);
        check("rst_serr", 32'(sync_err), 32'd0);
        model_clear();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [BITS-1:0] d;
        int iter;

        // Reset state
        repeat (2) @(negedge clk);
        check("por_valid", 32'(out_valid), 32'd0);
        check("por_data", 32'(data_out), 32'd0);
        check("por_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Directed group: a=0x10.., b=0x20.., c=0x30..
        for (int lane = 0; lane < IIR; lane++)
            for (int idx = 0; idx < N; idx++) begin
                d = BITS'(8'h10 * (lane + 1) + idx);
                step(1'b1, 1'b0, d);
            end
        idle(L + 2);

        // Three groups back-to-back, first sample of each marked with sync
        for (int i = 0; i < 3 * L; i++) step(1'b1, (i % L) == 0, BITS'($urandom));
        idle(L + 2);

        // Sync on the 6th sample restarts the group
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, BITS'($urandom));
        step(1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < L - 1; i++) step(1'b1, 1'b0, BITS'($urandom));
        idle(L + 2);

        // Reset after 5 outputs, then a clean group
        for (int i = 0; i < L; i++) step(1'b1, 1'b0, BITS'($urandom));
        idle(5);
        do_reset();
        for (int i = 0; i < L; i++) step(1'b1, 1'b0, BITS'(8'hC0 + i));
        idle(L + 2);

        // 20 groups with ~50% input gaps
        accepts = 0;
        iter    = 0;
        while (accepts < 20 * L && iter < 4000) begin
            step($urandom_range(0, 1) == 1, 1'b0, BITS'($urandom));
            iter++;
        end
        check("rand_accepts", 32'(accepts), 32'(20 * L));
        idle(L + 2);
        check("queue_drained", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
